// File: rtl/rggen_bit_field_rwl_lane.sv
// Write-lockable bit field split into independently lockable lanes, with an external lock and a write-count self-lock per lane.
// Optional sticky blocked-write flags: define RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN.
module rggen_bit_field_rwl_lane #(
    parameter int               WIDTH         = 32,
    parameter int               LANE_WIDTH    = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
    parameter int               WRITE_LIMIT   = 0,
    localparam int              LANES         = (WIDTH + LANE_WIDTH - 1) / LANE_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             bit_field_write_valid,
    input  logic [WIDTH-1:0] bit_field_write_mask,
    input  logic [WIDTH-1:0] bit_field_write_data,
    output logic [WIDTH-1:0] bit_field_read_data,
    output logic [WIDTH-1:0] bit_field_value,
    input  logic [LANES-1:0] i_lock,
    input  logic             i_count_clear,
`ifdef RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN
    output logic [LANES-1:0] o_violation,
`endif
    output logic [WIDTH-1:0] o_value,
    output logic [LANES-1:0] o_lane_locked
);

    localparam int COUNT_WIDTH = (WRITE_LIMIT == 0) ? 1 : $clog2(WRITE_LIMIT + 1);

    logic [WIDTH-1:0] value;
    logic [LANES-1:0] attempt;
    logic [LANES-1:0] accept;
    logic [LANES-1:0] limit_reached;

    assign bit_field_read_data = value;
    assign bit_field_value     = value;
    assign o_value             = value;
    assign o_lane_locked       = i_lock | limit_reached;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int LO = l * LANE_WIDTH;
        localparam int HI = (((l + 1) * LANE_WIDTH) > WIDTH) ? (WIDTH - 1) : (((l + 1) * LANE_WIDTH) - 1);

        assign attempt[l] = bit_field_write_valid & (|bit_field_write_mask[HI:LO]);
        assign accept[l]  = attempt[l] & ~o_lane_locked[l];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                value[HI:LO] <= INITIAL_VALUE[HI:LO];
            end else if (accept[l]) begin
                value[HI:LO] <= (bit_field_write_data[HI:LO] & bit_field_write_mask[HI:LO])
                              | (value[HI:LO] & ~bit_field_write_mask[HI:LO]);
            end
        end

        if (WRITE_LIMIT != 0) begin : g_counter
            logic [COUNT_WIDTH-1:0] count;

            assign limit_reached[l] = (count == COUNT_WIDTH'(WRITE_LIMIT));

            // An accepted write implies the lane is below the limit, so the increment never overflows.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    count <= '0;
                end else if (i_count_clear) begin
                    count <= '0;
                end else if (accept[l]) begin
                    count <= count + COUNT_WIDTH'(1);
                end
            end
        end else begin : g_no_counter
            assign limit_reached[l] = 1'b0;
        end

`ifdef RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                o_violation[l] <= 1'b0;
            end else if (i_count_clear) begin
                o_violation[l] <= 1'b0;
            end else if (attempt[l] && o_lane_locked[l]) begin
                o_violation[l] <= 1'b1;
            end
        end
`endif
    end

    logic unused_count_clear;
    assign unused_count_clear = i_count_clear;

endmodule

// File: tb/tb_rggen_bit_field_rwl_lane.sv
// Directed vector bench for rggen_bit_field_rwl_lane (16-bit field, 8-bit lanes, self-lock after 2 writes).
module tb_rggen_bit_field_rwl_lane;

    localparam int WIDTH = 16;
    localparam int LANES = 2;

    logic             i_clk;
    logic             i_rst_n;
    logic             write_valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] field_value;
    logic [LANES-1:0] i_lock;
    logic             i_count_clear;
    logic [WIDTH-1:0] o_value;
    logic [LANES-1:0] o_lane_locked;
`ifdef RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN
    logic [LANES-1:0] o_violation;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rggen_bit_field_rwl_lane #(
        .WIDTH         (16),
        .LANE_WIDTH    (8),
        .INITIAL_VALUE (16'h00A5),
        .WRITE_LIMIT   (2)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .bit_field_write_valid (write_valid),
        .bit_field_write_mask  (write_mask),
        .bit_field_write_data  (write_data),
        .bit_field_read_data   (read_data),
        .bit_field_value       (field_value),
        .i_lock                (i_lock),
        .i_count_clear         (i_count_clear),
`ifdef RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN
        .o_violation           (o_violation),
`endif
        .o_value               (o_value),
        .o_lane_locked         (o_lane_locked)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string            name;
        logic [LANES-1:0] lock;
        logic             valid;
        logic             clear;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] exp_value;
        logic [LANES-1:0] exp_locked;
        logic [LANES-1:0] exp_viol;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [WIDTH-1:0] exp_value,
                                 input logic [LANES-1:0] exp_locked, input logic [LANES-1:0] exp_viol);
        check({name, ".value"}, o_value, exp_value);
        check({name, ".read_data"}, read_data, exp_value);
        check({name, ".locked"}, {14'd0, o_lane_locked}, {14'd0, exp_locked});
`ifdef RGGEN_BIT_FIELD_RWL_LANE_VIOLATION_EN
        check({name, ".violation"}, {14'd0, o_violation}, {14'd0, exp_viol});
`else
        if (exp_viol === 2'bxx) $display("unreachable");
`endif
    endtask

    task automatic apply(input vec_t v);
        @(negedge i_clk);
        i_lock        = v.lock;
        write_valid   = v.valid;
        i_count_clear = v.clear;
        write_data    = v.data;
        write_mask    = v.mask;
        @(posedge i_clk);
        #1;
        write_valid   = 1'b0;
        i_count_clear = 1'b0;
        check_outputs(v.name, v.exp_value, v.exp_locked, v.exp_viol);
    endtask

    initial begin
        //           name       lock   vld   clr   data      mask      value     locked viol
        vecs.push_back('{"lock1",  2'b10, 1'b1, 1'b0, 16'h1234, 16'hFFFF, 16'h0034, 2'b10, 2'b10});
        vecs.push_back('{"nibble", 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 16'h0F3F, 2'b01, 2'b10});
        vecs.push_back('{"clr0",   2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0F3F, 2'b00, 2'b00});
        vecs.push_back('{"wr11",   2'b00, 1'b1, 1'b0, 16'h0011, 16'h00FF, 16'h0F11, 2'b00, 2'b00});
        vecs.push_back('{"wr22",   2'b00, 1'b1, 1'b0, 16'h0022, 16'h00FF, 16'h0F22, 2'b01, 2'b00});
        vecs.push_back('{"wr33",   2'b00, 1'b1, 1'b0, 16'h0033, 16'h00FF, 16'h0F22, 2'b01, 2'b01});
        vecs.push_back('{"lane1",  2'b00, 1'b1, 1'b0, 16'h5500, 16'hFF00, 16'h5522, 2'b01, 2'b01});
        vecs.push_back('{"clrwr",  2'b00, 1'b1, 1'b1, 16'hAB00, 16'hFF00, 16'hAB22, 2'b00, 2'b00});
        vecs.push_back('{"novld",  2'b00, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hAB22, 2'b00, 2'b00});
        vecs.push_back('{"mask0a", 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hAB22, 2'b00, 2'b00});
        vecs.push_back('{"mask0b", 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hAB22, 2'b00, 2'b00});
        vecs.push_back('{"split",  2'b00, 1'b1, 1'b0, 16'h0101, 16'h0101, 16'hAB23, 2'b00, 2'b00});
        vecs.push_back('{"split2", 2'b00, 1'b1, 1'b0, 16'h1000, 16'h1000, 16'hBB23, 2'b10, 2'b00});
        vecs.push_back('{"lck0",   2'b01, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hBB23, 2'b11, 2'b11});

        i_rst_n       = 1'b0;
        i_lock        = 2'b00;
        write_valid   = 1'b0;
        i_count_clear = 1'b0;
        write_data    = '0;
        write_mask    = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_outputs("reset", 16'h00A5, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset between edges must take effect without a clock edge.
        @(negedge i_clk);
        i_lock = 2'b10;
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 16'h00A5, 2'b10, 2'b00);
        @(negedge i_clk);
        i_lock  = 2'b00;
        i_rst_n = 1'b1;
        #1;
        check_outputs("post_rst", 16'h00A5, 2'b00, 2'b00);

        // Counters restart from zero after reset: two writes relock lane1.
        apply('{"rst_w1", 2'b00, 1'b1, 1'b0, 16'h7700, 16'hFF00, 16'h77A5, 2'b00, 2'b00});
        apply('{"rst_w2", 2'b00, 1'b1, 1'b0, 16'h8800, 16'hFF00, 16'h88A5, 2'b10, 2'b00});
        apply('{"rst_w3", 2'b00, 1'b1, 1'b0, 16'h9900, 16'hFF00, 16'h88A5, 2'b10, 2'b10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
